// File: rtl/board_io_pkg.sv
// board_io_pkg: shared constants for the board I/O controller.
// Button bit order is {btnc, btnr, btnd, btnl, btnu}.
package board_io_pkg;

    localparam int BTN_U   = 0;
    localparam int BTN_L   = 1;
    localparam int BTN_D   = 2;
    localparam int BTN_R   = 3;
    localparam int BTN_C   = 4;

    localparam int LED_W   = 8;
    localparam int BTN_W   = 5;
    localparam int SW_W    = 8;

    // Switch that selects automatic (1) or manual (0) owner selection
    localparam int SW_MODE = 7;

    // LED value shown when the owner is not requesting (no heartbeat build)
    localparam logic [LED_W-1:0] IDLE_PATTERN = 8'h00;

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: 2-FF synchronizer followed by a counter-based debouncer.
// The stable level flips once the synchronized input has disagreed with it
// for DEBOUNCE_CYCLES counted samples; any agreeing sample restarts the count.
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    // Two-flop synchronizer for the asynchronous board input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive disagreeing samples; adopt the new level at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync2 == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: debounces buttons/switches and arbitrates one LED bank
// between NUM_SRC requesters (manual via buttons, or automatic round-robin).
// Optional feature macro: BOARD_IO_HEARTBEAT_EN (idle LED shows a heartbeat).
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int NUM_SRC         = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DWELL_CYCLES    = 50000000,
    parameter int HB_DIV_LOG2     = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BTN_W-1:0]           btn_raw,
    input  logic [SW_W-1:0]            sw_raw,
    input  logic [NUM_SRC*LED_W-1:0]   src_leds,
    input  logic [NUM_SRC-1:0]         src_req,
    output logic [LED_W-1:0]           led,
    output logic [$clog2(NUM_SRC)-1:0] owner,
    output logic                       frozen,
    output logic [BTN_W-1:0]           btn_pulse,
    output logic [SW_W-1:0]            sw_db
);

    localparam int                 OWN_W      = $clog2(NUM_SRC);
    localparam logic [OWN_W-1:0]   OWN_LAST   = OWN_W'(NUM_SRC - 1);
    localparam int                 DWELL_W    = $clog2(DWELL_CYCLES);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam int                 IN_W       = BTN_W + SW_W;

    if (NUM_SRC < 2 || NUM_SRC > 8 || DEBOUNCE_CYCLES < 1 ||
        DWELL_CYCLES < 2 || HB_DIV_LOG2 < 1) begin : g_bad_params
        $error("board_io_ctrl: parameter out of range");
    end

    logic [IN_W-1:0]    w_raw_all;
    logic [IN_W-1:0]    w_db_all;
    logic [BTN_W-1:0]   w_btn_db;
    logic               w_mode;
    logic               w_mode_chg;
    logic               w_dwell_last;
    logic               w_dwell_tc;
    logic               w_frozen_next;
    logic [LED_W-1:0]   w_idle;
    logic [LED_W-1:0]   w_led_sel;
    logic [OWN_W-1:0]   w_owner_next;

    logic [BTN_W-1:0]   r_btn_prev;
    logic [BTN_W-1:0]   r_btn_pulse;
    logic               r_mode_prev;
    logic [DWELL_W-1:0] r_dwell;
    logic [OWN_W-1:0]   r_owner;
    logic               r_frozen;
    logic [LED_W-1:0]   r_led;

    // First requester after cur in wrap-around order; cur if nobody else asks
    function automatic logic [OWN_W-1:0] next_requester(
        input logic [OWN_W-1:0]   cur,
        input logic [NUM_SRC-1:0] req
    );
        logic [OWN_W-1:0] pick;
        logic             found;
        int               k;
        pick  = cur;
        found = 1'b0;
        for (int i = 1; i < NUM_SRC; i++) begin
            k = int'(cur) + i;
            if (k >= NUM_SRC) k = k - NUM_SRC;
            if (!found && req[k]) begin
                pick  = OWN_W'(k);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_raw_all = {sw_raw, btn_raw};

    for (genvar gi = 0; gi < IN_W; gi++) begin : g_debounce
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .i_raw   (w_raw_all[gi]),
            .o_level (w_db_all[gi])
        );
    end

    assign w_btn_db     = w_db_all[BTN_W-1:0];
    assign w_mode       = w_db_all[BTN_W + SW_MODE];
    assign w_mode_chg   = (w_mode != r_mode_prev);
    assign w_dwell_last = (r_dwell == DWELL_LAST);
    assign w_dwell_tc   = w_dwell_last && !w_mode_chg;

    // Registered one-cycle pulse on each debounced button rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_prev  <= '0;
            r_btn_pulse <= '0;
        end else begin
            r_btn_prev  <= w_btn_db;
            r_btn_pulse <= w_btn_db & ~r_btn_prev;
        end
    end

    // Dwell counter; restarts at terminal count or whenever the mode flips
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_prev <= 1'b0;
            r_dwell     <= '0;
        end else begin
            r_mode_prev <= w_mode;
            if (w_mode_chg || w_dwell_last) r_dwell <= '0;
            else                            r_dwell <= r_dwell + DWELL_W'(1);
        end
    end

    // Owner selection: round-robin on dwell expiry, or button stepping
    always_comb begin
        w_owner_next = r_owner;
        if (w_mode) begin
            if (w_dwell_tc) w_owner_next = next_requester(r_owner, src_req);
        end else if (r_btn_pulse[BTN_U]) begin
            w_owner_next = '0;
        end else if (r_btn_pulse[BTN_R] && !r_btn_pulse[BTN_L]) begin
            w_owner_next = (r_owner == OWN_LAST) ? '0 : r_owner + OWN_W'(1);
        end else if (r_btn_pulse[BTN_L] && !r_btn_pulse[BTN_R]) begin
            w_owner_next = (r_owner == '0) ? OWN_LAST : r_owner - OWN_W'(1);
        end
    end

    // Owner register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_owner <= '0;
        else     r_owner <= w_owner_next;
    end

`ifdef BOARD_IO_HEARTBEAT_EN
    logic [HB_DIV_LOG2-1:0] r_hb_cnt;

    // Free-running heartbeat divider; its MSB blinks led[0] when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_hb_cnt <= '0;
        else     r_hb_cnt <= r_hb_cnt + HB_DIV_LOG2'(1);
    end

    assign w_idle = {{(LED_W-1){1'b0}}, r_hb_cnt[HB_DIV_LOG2-1]};
`else
    assign w_idle = IDLE_PATTERN;
`endif

    // The freeze toggle applies before this cycle's LED load, so a freeze
    // landing together with an owner change keeps the currently shown value
    assign w_frozen_next = r_frozen ^ r_btn_pulse[BTN_C];
    assign w_led_sel     = src_req[r_owner] ? src_leds[int'(r_owner)*LED_W +: LED_W]
                                            : w_idle;

    // Freeze flag and LED register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frozen <= 1'b0;
            r_led    <= '0;
        end else begin
            r_frozen <= w_frozen_next;
            if (!w_frozen_next) r_led <= w_led_sel;
        end
    end

    assign led       = r_led;
    assign owner     = r_owner;
    assign frozen    = r_frozen;
    assign btn_pulse = r_btn_pulse;
    assign sw_db     = w_db_all[IN_W-1:BTN_W];

endmodule

// File: tb/tb_board_io_ctrl.sv
// tb_board_io_ctrl: directed + randomized bench with a cycle-level reference
// model built from event timing (press/switch schedules, dwell phase math).
module tb_board_io_ctrl;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int DW = 16;
    localparam int HB = 4;
`ifdef BOARD_IO_HEARTBEAT_EN
    localparam bit HB_EN = 1'b1;
`else
    localparam bit HB_EN = 1'b0;
`endif

    localparam logic [4:0] B_U = 5'b00001;
    localparam logic [4:0] B_L = 5'b00010;
    localparam logic [4:0] B_D = 5'b00100;
    localparam logic [4:0] B_R = 5'b01000;
    localparam logic [4:0] B_C = 5'b10000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [4:0]    btn_raw;
    logic [7:0]    sw_raw;
    logic [N*8-1:0] src_leds;
    logic [N-1:0]  src_req;
    logic [7:0]    led;
    logic [1:0]    owner;
    logic          frozen;
    logic [4:0]    btn_pulse;
    logic [7:0]    sw_db;

    always #5 clk = ~clk;

    board_io_ctrl #(
        .NUM_SRC(N), .DEBOUNCE_CYCLES(D), .DWELL_CYCLES(DW), .HB_DIV_LOG2(HB)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .src_leds(src_leds), .src_req(src_req), .led(led), .owner(owner),
        .frozen(frozen), .btn_pulse(btn_pulse), .sw_db(sw_db)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int         cyc;
    int         base_b;
    int         clr_edge;
    int         m_owner;
    logic       m_frozen;
    logic [7:0] m_led;
    logic [7:0] m_sw;
    logic [4:0] m_pulse;
    logic [4:0] pulse_sched [int];
    logic [7:0] sw_sched [int];
    logic [4:0] masks [6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Idle pattern seen at edge e: heartbeat counter value before that edge is e-1
    function automatic logic [7:0] idle_at(input int e);
        logic [31:0] c;
        c = 32'(e - 1);
        return HB_EN ? {7'b0, c[HB-1]} : 8'h00;
    endfunction

    function automatic int pick_next(input int cur, input logic [N-1:0] req);
        for (int i = 1; i < N; i++)
            if (req[(cur + i) % N]) return (cur + i) % N;
        return cur;
    endfunction

    // Advance one clock, update the model from pre-edge inputs, then check
    task automatic step();
        logic [N-1:0]   p_req;
        logic [N*8-1:0] p_leds;
        logic [4:0]     p_pulse;
        logic           p_mode;
        logic           fz_next;
        logic           tc;
        logic [7:0]     v;
        p_req   = src_req;
        p_leds  = src_leds;
        p_pulse = m_pulse;
        p_mode  = m_sw[7];
        @(posedge clk);
        cyc++;
        fz_next = m_frozen ^ p_pulse[4];
        if (!fz_next) m_led = p_req[m_owner] ? p_leds[m_owner*8 +: 8] : idle_at(cyc);
        m_frozen = fz_next;
        if (cyc == clr_edge) begin
            base_b = cyc;
            tc     = 1'b0;
        end else begin
            tc = ((cyc - base_b) % DW) == 0;
        end
        if (p_mode) begin
            if (tc) m_owner = pick_next(m_owner, p_req);
        end else if (p_pulse[0]) begin
            m_owner = 0;
        end else if (p_pulse[3] && !p_pulse[1]) begin
            m_owner = (m_owner + 1) % N;
        end else if (p_pulse[1] && !p_pulse[3]) begin
            m_owner = (m_owner + N - 1) % N;
        end
        m_pulse = pulse_sched.exists(cyc) ? pulse_sched[cyc] : 5'd0;
        if (sw_sched.exists(cyc)) begin
            v = sw_sched[cyc];
            if (v[7] != m_sw[7]) clr_edge = cyc + 1;
            m_sw = v;
        end
        #1;
        chk("btn_pulse", 32'(btn_pulse), 32'(m_pulse));
        chk("owner",     32'(owner),     32'(m_owner));
        chk("frozen",    32'(frozen),    32'(m_frozen));
        chk("led",       32'(led),       32'(m_led));
        chk("sw_db",     32'(sw_db),     32'(m_sw));
    endtask

    // Clean press: the first sampling edge is cyc+1, pulse appears D+3 later
    task automatic press(input logic [4:0] mask);
        btn_raw = btn_raw | mask;
        pulse_sched[cyc + 1 + D + 3] = mask;
        repeat (D + 6) step();
        btn_raw = btn_raw & ~mask;
        repeat (D + 4) step();
    endtask

    task automatic set_sw(input logic [7:0] v);
        sw_raw = v;
        sw_sched[cyc + 1 + D + 2] = v;
        repeat (D + 4) step();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        btn_raw = '0;
        sw_raw  = '0;
        #1;
        chk("rst_led",       32'(led),       32'h0);
        chk("rst_owner",     32'(owner),     32'h0);
        chk("rst_frozen",    32'(frozen),    32'h0);
        chk("rst_btn_pulse", 32'(btn_pulse), 32'h0);
        chk("rst_sw_db",     32'(sw_db),     32'h0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        cyc      = 0;
        base_b   = 0;
        clr_edge = -1;
        m_owner  = 0;
        m_frozen = 1'b0;
        m_led    = 8'h00;
        m_sw     = 8'h00;
        m_pulse  = 5'h00;
        pulse_sched.delete();
        sw_sched.delete();
    endtask

    initial begin
        masks[0] = B_U; masks[1] = B_L; masks[2] = B_R;
        masks[3] = B_D; masks[4] = B_L | B_R; masks[5] = B_U | B_R;
        btn_raw  = '0;
        sw_raw   = '0;
        src_leds = '0;
        src_req  = '0;
        cyc      = 0;
        #1;
        do_reset();

        src_req  = 4'hF;
        src_leds = $urandom();
        repeat (3) step();

        // Debounce: short glitches, then a clean held btnr
        btn_raw[3] = 1'b1; step();
        btn_raw[3] = 1'b0; step();
        btn_raw[3] = 1'b1; step();
        btn_raw[3] = 1'b0; step();
        press(B_R);
        chk("deb_owner", 32'(owner), 32'd1);

        // Manual wrap cases
        press(B_R); press(B_R);
        chk("man_owner3", 32'(owner), 32'd3);
        press(B_R);
        chk("man_wrap_up", 32'(owner), 32'd0);
        press(B_L);
        chk("man_wrap_dn", 32'(owner), 32'd3);
        press(B_L | B_R);
        chk("man_lr_hold", 32'(owner), 32'd3);
        press(B_L);
        chk("man_owner2", 32'(owner), 32'd2);
        press(B_U);
        chk("man_btnu", 32'(owner), 32'd0);

        // Randomized manual traffic
        for (int it = 0; it < 16; it++) begin
            src_leds = $urandom();
            src_req  = 4'($urandom());
            press(masks[$urandom_range(0, 5)]);
            repeat ($urandom_range(0, 3)) step();
        end

        // Freeze / unfreeze
        press(B_U);
        src_req       = 4'hF;
        src_leds[7:0] = 8'hA5;
        repeat (2) step();
        chk("frz_pre_led", 32'(led), 32'hA5);
        press(B_C);
        chk("frz_on", 32'(frozen), 32'd1);
        src_leds[7:0] = 8'h3C;
        repeat (4) step();
        chk("frz_hold_led", 32'(led), 32'hA5);
        press(B_C);
        chk("frz_off", 32'(frozen), 32'd0);
        chk("frz_new_led", 32'(led), 32'h3C);

        // Idle pattern
        src_req = 4'h0;
        repeat (20) step();
        chk("idle_upper", 32'(led[7:1]), 32'd0);

        // Automatic rotation
        src_req = 4'b1010;
        set_sw(8'h80);
        repeat (DW) step();
        chk("auto_1", 32'(owner), 32'd1);
        repeat (DW) step();
        chk("auto_3", 32'(owner), 32'd3);
        repeat (DW) step();
        chk("auto_1b", 32'(owner), 32'd1);
        src_req = 4'b0010;
        repeat (DW) step();
        chk("auto_stay", 32'(owner), 32'd1);
        press(B_L);
        chk("auto_ign_btn", 32'(owner), 32'd1);

        // Request churn in automatic mode
        for (int it = 0; it < 48; it++) begin
            src_req  = 4'($urandom());
            src_leds = $urandom();
            step();
        end

        // Reset mid-operation: automatic, frozen, debounce in progress
        src_req = 4'b1010;
        repeat (DW + 1) step();
        press(B_C);
        chk("pre_rst_frozen", 32'(frozen), 32'd1);
        chk("pre_rst_mode", 32'(sw_db[7]), 32'd1);
        btn_raw[3] = 1'b1;
        repeat (3) step();
        do_reset();

        // 3-cycle btnc glitch after reset must not pulse
        btn_raw[4] = 1'b1;
        repeat (3) step();
        btn_raw[4] = 1'b0;
        repeat (12) step();
        chk("glitch_frozen", 32'(frozen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
